// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg
//   Shared definitions for the ID-stage control decode slice:
//   RV32 opcode/funct7 constants, ALU-op groups, immediate-type (IMM_TYPE)
//   encodings, branch/jump and write-back select encodings, the div-hold
//   FSM state enum and the registered control-bundle struct.
//   Build option: RV32M_DECODE_EN (see ctrl_decode_comb / ctrl_decode_seq).
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // alu_op = {group, funct3}; group selects base / alternate (SUB, SRA) / M-ext.
  localparam logic [1:0] ALU_GRP_BASE = 2'b00;
  localparam logic [1:0] ALU_GRP_ALT  = 2'b01;
  localparam logic [1:0] ALU_GRP_MD   = 2'b10;
  localparam logic [4:0] ALU_ADD      = 5'b00000;
  localparam logic [4:0] ALU_SUB      = 5'b01000;
  localparam logic [4:0] ALU_PASSB    = 5'b11000;

  // IMM_TYPE encodings carried on imm_sel.
  localparam logic [3:0] IMM_NONE = 4'd0;
  localparam logic [3:0] IMM_I    = 4'd1;
  localparam logic [3:0] IMM_S    = 4'd2;
  localparam logic [3:0] IMM_B    = 4'd3;
  localparam logic [3:0] IMM_U    = 4'd4;
  localparam logic [3:0] IMM_J    = 4'd5;

  localparam logic [2:0] BJ_NONE   = 3'b000;
  localparam logic [2:0] BJ_BRANCH = 3'b001;
  localparam logic [2:0] BJ_JAL    = 3'b010;
  localparam logic [2:0] BJ_JALR   = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DIVHOLD = 1'b1
  } state_e;

  // mem_write = {store, size}; mem_read = {load, funct3}.
  typedef struct packed {
    logic [4:0] alu_op;
    logic       reg_write_en;
    logic [2:0] mem_write;
    logic [3:0] mem_read;
    logic [2:0] branch_jump;
    logic [3:0] imm_sel;
    logic       data1_alu_sel;  // 1: PC as operand A
    logic       data2_alu_sel;  // 1: immediate as operand B
    logic [1:0] wb_sel;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb
//   Purely combinational RV32I(+M) instruction decoder.
//   Ports:
//     instr_i   in  32  instruction word
//     ctrl_o    out     control bundle (ctrl_t)
//     illegal_o out  1  unknown opcode / funct7
//     is_div_o  out  1  DIV/DIVU/REM/REMU (only with RV32M_DECODE_EN)
//   Build option: RV32M_DECODE_EN enables funct7=0000001 R-type decode.
module ctrl_decode_comb
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o,
  output logic        is_div_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Register specifiers are not needed for control decode.
  logic unused_fields;
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    is_div_o  = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl_o.reg_write_en  = 1'b1;
        ctrl_o.imm_sel       = IMM_U;
        ctrl_o.data2_alu_sel = 1'b1;
        ctrl_o.alu_op        = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write_en  = 1'b1;
        ctrl_o.imm_sel       = IMM_U;
        ctrl_o.data1_alu_sel = 1'b1;
        ctrl_o.data2_alu_sel = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.reg_write_en  = 1'b1;
        ctrl_o.imm_sel       = IMM_J;
        ctrl_o.data1_alu_sel = 1'b1;
        ctrl_o.data2_alu_sel = 1'b1;
        ctrl_o.branch_jump   = BJ_JAL;
        ctrl_o.wb_sel        = WB_PC4;
      end
      OP_JALR: begin
        ctrl_o.reg_write_en  = 1'b1;
        ctrl_o.imm_sel       = IMM_I;
        ctrl_o.data2_alu_sel = 1'b1;
        ctrl_o.branch_jump   = BJ_JALR;
        ctrl_o.wb_sel        = WB_PC4;
      end
      OP_BRANCH: begin
        ctrl_o.imm_sel     = IMM_B;
        ctrl_o.branch_jump = BJ_BRANCH;
        ctrl_o.alu_op      = ALU_SUB;
      end
      OP_LOAD: begin
        ctrl_o.reg_write_en  = 1'b1;
        ctrl_o.imm_sel       = IMM_I;
        ctrl_o.data2_alu_sel = 1'b1;
        ctrl_o.mem_read      = {1'b1, funct3};
        ctrl_o.wb_sel        = WB_MEM;
      end
      OP_STORE: begin
        ctrl_o.imm_sel       = IMM_S;
        ctrl_o.data2_alu_sel = 1'b1;
        ctrl_o.mem_write     = {1'b1, funct3[1:0]};
      end
      OP_IMM: begin
        ctrl_o.reg_write_en  = 1'b1;
        ctrl_o.imm_sel       = IMM_I;
        ctrl_o.data2_alu_sel = 1'b1;
        ctrl_o.alu_op        = {ALU_GRP_BASE, funct3};
        // funct7 is only an opcode extension for the shift-immediates.
        if (funct3 == 3'b001) begin
          if (funct7 != F7_BASE) illegal_o = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) ctrl_o.alu_op = {ALU_GRP_ALT, funct3};
          else if (funct7 != F7_BASE) illegal_o = 1'b1;
        end
      end
      OP_REG: begin
        ctrl_o.reg_write_en = 1'b1;
        case (funct7)
          F7_BASE: ctrl_o.alu_op = {ALU_GRP_BASE, funct3};
          F7_ALT: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) ctrl_o.alu_op = {ALU_GRP_ALT, funct3};
            else illegal_o = 1'b1;
          end
          F7_MULDIV: begin
`ifdef RV32M_DECODE_EN
            ctrl_o.alu_op = {ALU_GRP_MD, funct3};
            is_div_o      = funct3[2];
`else
            illegal_o = 1'b1;
`endif
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_FENCE, OP_SYSTEM: begin
        ctrl_o = '0;
      end
      default: illegal_o = 1'b1;
    endcase
    // An illegal instruction must never write architectural or memory state.
    if (illegal_o) begin
      ctrl_o.reg_write_en = 1'b0;
      ctrl_o.mem_write    = '0;
      ctrl_o.mem_read     = '0;
    end
  end

endmodule

// File: rtl/ctrl_decode_seq.sv
// ctrl_decode_seq
//   ID-stage control decode with valid/ready handshake, one-cycle registered
//   control bundle and a divide hold that stalls decode for DIV_CYCLES.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     instr, in_valid       instruction from IF/ID; in_ready = accepted
//     out_valid, out_ready  control bundle handshake toward ID/EX
//     flush                 kill held bundle and any divide hold
//     alu_op .. wb_sel      registered control bundle
//     illegal, busy         registered illegal flag, divide hold active
//   Build option: RV32M_DECODE_EN enables M-extension decode and the hold FSM;
//   without it busy is tied 0.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | decode accepting when output slot is free
//   ST_DIVHOLD | divide issued; in_ready low while counter runs
module ctrl_decode_seq
  import rv32_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [4:0]  alu_op,
  output logic        reg_write_en,
  output logic [2:0]  mem_write,
  output logic [3:0]  mem_read,
  output logic [2:0]  branch_jump,
  output logic [3:0]  imm_sel,
  output logic        data1_alu_sel,
  output logic        data2_alu_sel,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        busy
);

  if (DIV_CYCLES < 2 || DIV_CYCLES > 64 || (2 ** CNT_W) < DIV_CYCLES) begin : g_param_chk
    $error("ctrl_decode_seq: DIV_CYCLES must be 2..64 and fit in CNT_W bits");
  end

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  dec_is_div;

  ctrl_decode_comb u_dec (
    .instr_i   (instr),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .is_div_o  (dec_is_div)
  );

  ctrl_t bundle_q;
  logic  out_valid_q;
  logic  illegal_q;
  logic  busy_int;
  logic  accept;

  // Flush wins over a same-cycle accept, so in_ready drops with it to keep
  // the upstream handshake truthful.
  assign in_ready = !busy_int && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      bundle_q    <= dec_ctrl;
      illegal_q   <= dec_illegal;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef RV32M_DECODE_EN
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter loads DIV_CYCLES-1 and the hold exits the cycle after it reads 0,
  // giving DIV_CYCLES busy cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && dec_is_div) begin
          state_d = ST_DIVHOLD;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      ST_DIVHOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign busy_int = (state_q == ST_DIVHOLD);
`else
  logic unused_is_div;
  assign unused_is_div = dec_is_div;
  assign busy_int      = 1'b0;
`endif

  assign out_valid     = out_valid_q;
  assign illegal       = illegal_q;
  assign busy          = busy_int;
  assign alu_op        = bundle_q.alu_op;
  assign reg_write_en  = bundle_q.reg_write_en;
  assign mem_write     = bundle_q.mem_write;
  assign mem_read      = bundle_q.mem_read;
  assign branch_jump   = bundle_q.branch_jump;
  assign imm_sel       = bundle_q.imm_sel;
  assign data1_alu_sel = bundle_q.data1_alu_sel;
  assign data2_alu_sel = bundle_q.data2_alu_sel;
  assign wb_sel        = bundle_q.wb_sel;

endmodule
